// File: rtl/mips_mem_responder.sv
// Byte-addressed big-endian word memory on the responder side of the CPU's
// fetch/load/store port. One request at a time, response after LATENCY edges,
// with a preload port and completed-read/write counters.
module mips_mem_responder #(
    parameter int MEM_SIZE   = 12,
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 1
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_rready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic        load_valid,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [31:0] read_count,
    output logic [31:0] write_count
);

    localparam int unsigned DEPTH     = 1 << MEM_SIZE;
    localparam logic [31:0] LAST_WORD = 32'((1 << MEM_SIZE) - 4);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t        state;
    logic [3:0]    cnt;
    logic          op_write;
    logic [31:0]   op_addr;
    logic [31:0]   op_wdata;

    logic                op_in_range;
    logic                load_in_range;
    logic [MEM_SIZE-1:0] op_idx;
    logic [MEM_SIZE-1:0] load_idx;
    logic [31:0]         op_word;
    logic                exec_now;
    logic                store_commit;
    logic                load_commit;

    // No wrap-around: any word whose last byte falls past the top is an error.
    assign op_in_range   = (op_addr <= LAST_WORD);
    assign load_in_range = (load_addr <= LAST_WORD);
    assign op_idx        = op_addr[MEM_SIZE-1:0];
    assign load_idx      = load_addr[MEM_SIZE-1:0];

    assign op_word = {mem[op_idx][7:0],
                      mem[op_idx + MEM_SIZE'(1)][7:0],
                      mem[op_idx + MEM_SIZE'(2)][7:0],
                      mem[op_idx + MEM_SIZE'(3)][7:0]};

    assign exec_now     = (state == BUSY) && (cnt == '0);
    assign store_commit = exec_now && op_write && op_in_range && !RESET;
    assign load_commit  = (state == IDLE) && load_valid && load_in_range && !RESET;

    // Preload has the port while idle, so it is refused to requests that cycle.
    assign req_ready = (state == IDLE) && !load_valid;

    // Memory array: preload writes in IDLE, committed stores at execution time.
    always_ff @(posedge CLOCK) begin
        if (load_commit) begin
            for (int unsigned k = 0; k < 4; k++)
                mem[load_idx + MEM_SIZE'(k)] <= DATA_WIDTH'(load_data[31-8*k -: 8]);
        end else if (store_commit) begin
            for (int unsigned k = 0; k < 4; k++)
                mem[op_idx + MEM_SIZE'(k)] <= DATA_WIDTH'(op_wdata[31-8*k -: 8]);
        end
    end

    // Request/response FSM with registered response outputs and counters.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= IDLE;
            cnt         <= '0;
            op_write    <= 1'b0;
            op_addr     <= '0;
            op_wdata    <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            read_count  <= '0;
            write_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!load_valid && req_valid) begin
                        op_write <= req_write;
                        op_addr  <= req_addr;
                        op_wdata <= req_wdata;
                        cnt      <= 4'(LATENCY - 1);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        resp_valid <= 1'b1;
                        if (!op_in_range) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (op_write) begin
                            resp_rdata <= '0;
                        end else begin
                            resp_rdata <= op_word;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_rready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        if (op_write)
                            write_count <= write_count + 32'd1;
                        else
                            read_count <= read_count + 32'd1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: LATENCY=1 instance driven by a directed table,
// an arbitration sequence and random traffic against a byte-array model;
// LATENCY=4 instance for backpressure, busy-time preload and reset mid-write.
module tb_mips_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ---------------- instance A (LATENCY=1) ----------------
    logic        a_rst, a_req_valid, a_req_ready, a_req_write;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic        a_resp_valid, a_resp_rready, a_resp_err, a_load_valid;
    logic [31:0] a_load_addr, a_load_data, a_read_count, a_write_count;

    mips_mem_responder #(.MEM_SIZE(12), .DATA_WIDTH(8), .LATENCY(1)) u_dut_a (
        .CLOCK(clk), .RESET(a_rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_rready(a_resp_rready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .load_valid(a_load_valid), .load_addr(a_load_addr), .load_data(a_load_data),
        .read_count(a_read_count), .write_count(a_write_count)
    );

    // ---------------- instance B (LATENCY=4) ----------------
    logic        b_rst, b_req_valid, b_req_ready, b_req_write;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic        b_resp_valid, b_resp_rready, b_resp_err, b_load_valid;
    logic [31:0] b_load_addr, b_load_data, b_read_count, b_write_count;

    mips_mem_responder #(.MEM_SIZE(12), .DATA_WIDTH(8), .LATENCY(4)) u_dut_b (
        .CLOCK(clk), .RESET(b_rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rready(b_resp_rready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .load_valid(b_load_valid), .load_addr(b_load_addr), .load_data(b_load_data),
        .read_count(b_read_count), .write_count(b_write_count)
    );

    // ---------------- reference model for A ----------------
    logic [7:0]  model_mem [4096];
    int unsigned m_reads  = 0;
    int unsigned m_writes = 0;

    function automatic bit m_in_range(input logic [31:0] a);
        return a <= 32'd4092;
    endfunction

    task automatic m_apply(input bit w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] exp_rdata, output bit exp_err);
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        if (!m_in_range(a)) begin
            exp_err = 1'b1;
        end else if (w) begin
            for (int k = 0; k < 4; k++) model_mem[a + k] = d[31-8*k -: 8];
        end else begin
            for (int k = 0; k < 4; k++) exp_rdata[31-8*k -: 8] = model_mem[a + k];
        end
        if (w) m_writes++; else m_reads++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic a_load(input logic [31:0] a, input logic [31:0] d);
        a_load_valid = 1'b1; a_load_addr = a; a_load_data = d;
        @(posedge clk); #1;
        a_load_valid = 1'b0;
        if (m_in_range(a))
            for (int k = 0; k < 4; k++) model_mem[a + k] = d[31-8*k -: 8];
    endtask

    task automatic a_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rdata, output bit err, output int lat);
        a_req_write = w; a_req_addr = a; a_req_wdata = d; a_req_valid = 1'b1;
        #1;
        chk("a_ready_before_req", a_req_ready, 1);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!a_resp_valid && lat < 20);
        rdata = a_resp_rdata;
        err   = a_resp_err;
        a_resp_rready = 1'b1;
        @(posedge clk); #1;
        a_resp_rready = 1'b0;
        chk("a_resp_valid_drop", a_resp_valid, 0);
        chk("a_ready_after_resp", a_req_ready, 1);
    endtask

    task automatic b_load(input logic [31:0] a, input logic [31:0] d);
        b_load_valid = 1'b1; b_load_addr = a; b_load_data = d;
        @(posedge clk); #1;
        b_load_valid = 1'b0;
    endtask

    // Issues a request on B and returns once resp_valid is seen (or budget expires).
    task automatic b_issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                           output int lat);
        b_req_write = w; b_req_addr = a; b_req_wdata = d; b_req_valid = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!b_resp_valid && lat < 30);
    endtask

    task automatic b_handshake();
        b_resp_rready = 1'b1;
        @(posedge clk); #1;
        b_resp_rready = 1'b0;
    endtask

    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] rd, exp_rd;
    bit          er, exp_er;
    int          lat;

    initial begin
        a_rst = 1'b1; a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0;
        a_req_wdata = '0; a_resp_rready = 1'b0; a_load_valid = 1'b0;
        a_load_addr = '0; a_load_data = '0;
        b_rst = 1'b1; b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0;
        b_req_wdata = '0; b_resp_rready = 1'b0; b_load_valid = 1'b0;
        b_load_addr = '0; b_load_data = '0;

        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0;

        chk("rst_req_ready", a_req_ready, 1);
        chk("rst_resp_valid", a_resp_valid, 0);
        chk("rst_resp_rdata", a_resp_rdata, 0);
        chk("rst_resp_err", a_resp_err, 0);
        chk("rst_read_count", a_read_count, 0);
        chk("rst_write_count", a_write_count, 0);

        // Define every byte, then overlay the directed image.
        for (int i = 0; i < 4096; i += 4) a_load(i, $urandom);
        a_load(32'h000, 32'h8C220004);
        a_load(32'h014, 32'hAA000000);
        a_load(32'hFFC, 32'hCAFEBABE);

        tbl[0] = '{0, 32'h000,      32'h0,        32'h8C220004, 0};
        tbl[1] = '{1, 32'h010,      32'h11223344, 32'h0,        0};
        tbl[2] = '{0, 32'h011,      32'h0,        32'h223344AA, 0};
        tbl[3] = '{1, 32'hFFD,      32'hFFFFFFFF, 32'h0,        1};
        tbl[4] = '{0, 32'hFFC,      32'h0,        32'hCAFEBABE, 0};
        tbl[5] = '{0, 32'h1000,     32'h0,        32'h0,        1};
        tbl[6] = '{0, 32'hFFFFFFFC, 32'h0,        32'h0,        1};
        tbl[7] = '{0, 32'h010,      32'h0,        32'h11223344, 0};
        tbl[8] = '{0, 32'h012,      32'h0,        32'h3344AA00, 0};

        for (int i = 0; i < 9; i++) begin
            m_apply(tbl[i].w, tbl[i].addr, tbl[i].wdata, exp_rd, exp_er);
            a_txn(tbl[i].w, tbl[i].addr, tbl[i].wdata, rd, er, lat);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
            chk($sformatf("tbl%0d_latency", i), lat, 1);
            if (i == 0) chk("tbl0_read_count", a_read_count, 1);
        end
        chk("tbl_read_count", a_read_count, 7);
        chk("tbl_write_count", a_write_count, 2);

        // Simultaneous preload and request: preload wins, request follows.
        a_req_write = 1'b0; a_req_addr = 32'h100; a_req_valid = 1'b1;
        a_load_valid = 1'b1; a_load_addr = 32'h100; a_load_data = 32'h0BADF00D;
        #1;
        chk("arb_ready_low", a_req_ready, 0);
        @(posedge clk); #1;
        a_load_valid = 1'b0;
        for (int k = 0; k < 4; k++) model_mem[32'h100 + k] = 8'(32'h0BADF00D >> (24 - 8*k));
        m_apply(0, 32'h100, 0, exp_rd, exp_er);
        a_txn(0, 32'h100, 0, rd, er, lat);
        chk("arb_rdata", rd, 32'h0BADF00D);
        chk("arb_latency", lat, 1);

        // Random traffic, biased to a small window for read-after-write overlap.
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            bit          w;
            logic [31:0] a, d;
            r = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (r == 0)      a = 32'd4093 + $urandom_range(0, 2);
            else if (r == 1) a = $urandom;
            else if (r < 6)  a = $urandom_range(32'h200, 32'h210);
            else             a = $urandom_range(0, 4092);
            m_apply(w, a, d, exp_rd, exp_er);
            a_txn(w, a, d, rd, er, lat);
            chk("rnd_rdata", rd, exp_rd);
            chk("rnd_err", {31'b0, er}, {31'b0, exp_er});
            chk("rnd_latency", lat, 1);
            chk("rnd_read_count", a_read_count, m_reads);
            chk("rnd_write_count", a_write_count, m_writes);
        end

        // ---------------- B: backpressure ----------------
        b_load(32'h040, 32'h5A5AA5A5);
        b_load(32'h020, 32'h01020304);
        b_issue(0, 32'h040, 0, lat);
        chk("bp_latency", lat, 4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", b_resp_valid, 1);
            chk("bp_hold_rdata", b_resp_rdata, 32'h5A5AA5A5);
            chk("bp_hold_ready", b_req_ready, 0);
        end
        b_handshake();
        chk("bp_valid_drop", b_resp_valid, 0);
        chk("bp_ready_back", b_req_ready, 1);
        chk("bp_read_count", b_read_count, 1);

        // Preload attempted while BUSY must be ignored.
        b_req_write = 1'b0; b_req_addr = 32'h040; b_req_valid = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        b_load_valid = 1'b1; b_load_addr = 32'h040; b_load_data = 32'h0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!b_resp_valid && lat < 30);
        b_load_valid = 1'b0;
        chk("busy_load_latency", lat, 4);
        chk("busy_load_rdata", b_resp_rdata, 32'h5A5AA5A5);
        b_handshake();
        b_issue(0, 32'h040, 0, lat);
        chk("busy_load_reread", b_resp_rdata, 32'h5A5AA5A5);
        b_handshake();
        chk("b_read_count_pre_rst", b_read_count, 3);

        // Reset one edge after a write is accepted: the write never lands.
        b_req_write = 1'b1; b_req_addr = 32'h020; b_req_wdata = 32'hDEADBEEF;
        b_req_valid = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        b_rst = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0;
        chk("rstmid_resp_valid", b_resp_valid, 0);
        chk("rstmid_read_count", b_read_count, 0);
        chk("rstmid_write_count", b_write_count, 0);
        chk("rstmid_req_ready", b_req_ready, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("rstmid_no_resp", b_resp_valid, 0);
        b_issue(0, 32'h020, 0, lat);
        chk("rstmid_latency", lat, 4);
        chk("rstmid_mem_kept", b_resp_rdata, 32'h01020304);
        chk("rstmid_err", b_resp_err, 0);
        b_handshake();
        chk("rstmid_read_after", b_read_count, 1);
        chk("rstmid_write_after", b_write_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
